uart_rx_sampler: RTL
====================

# uart_rx_sampler

Synthesizable 8-bit UART receiver that decodes the serial stream arriving on the board's UART RX pin and presents bytes to the SoC side through a small FIFO with a valid/ready handshake. It is the receive-direction counterpart of the SoC's UART transmit path. It sits between the `UART_RXD` top-level pin and the peripheral bus glue inside `fpgaTop`. It uses 16x oversampling, a 2-FF input synchronizer, majority-vote bit sampling, optional parity, and flags for framing, parity and overrun errors.

## Interface
- `CLK_FREQ_HZ`, 50_000_000 — system clock frequency.
- `BAUD`, 115200 — line rate.
- `PARITY_EN`, 0 — 1: one parity bit follows the data bits.
- `PARITY_ODD`, 0 — 1: odd parity, 0: even parity. Ignored when `PARITY_EN`=0.
- `FIFO_DEPTH`, 4 — receive FIFO entries; must be a power of 2 and ≥2.
- Derived: `DIV` = round(`CLK_FREQ_HZ`/(`BAUD`*16)), minimum 1. Defaults give `DIV`=27, so one bit is 432 cycles.
- `clk`  in  1  — system clock (`CLOCK_50` domain).
- `reset_n`  in  1  — synchronous, active-low reset.
- `rxd`  in  1  — asynchronous serial input; idle level is 1.
- `m_data`  out  8  — FIFO head byte.
- `m_valid`  out  1  — FIFO is not empty.
- `m_ready`  in  1  — consumer accepts the head byte.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  — number of occupied entries.
- `rx_busy`  out  1  — a frame is in progress (state is neither IDLE nor WAIT_IDLE).
- `frame_err`  out  1  — 1-cycle pulse when the stop bit is sampled as 0.
- `parity_err`  out  1  — 1-cycle pulse when parity mismatches.
- `overrun`  out  1  — 1-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation
- Synchronizer: two flops, both reset to 1. All logic uses `rx_s`, the second stage.
- Tick generator: counts 0..`DIV`-1 and asserts `tick` on terminal count. It runs freely and is cleared on start detection.
- `os_cnt` (0..15) advances on each `tick`. Samples are taken at `os_cnt`=7, 8 and 9. The bit value is the 2-of-3 majority, committed at `os_cnt`=9. `os_cnt`=15 ends the bit.
- State machine:
  - IDLE: when `rx_s`=0 and the previous `rx_s`=1, go to START and clear the tick divider and `os_cnt`.
  - START: at commit, a majority of 1 is a false start → IDLE, no flags. A majority of 0 → DATA at bit end.
  - DATA: 8 bits, LSB first, shifted into `shreg`. After bit 7 ends, go to PARITY if `PARITY_EN`, else STOP.
  - PARITY: at commit, compare against the XOR of the data, inverted when `PARITY_ODD`. Store the mismatch. Go to STOP at bit end.
  - STOP: at commit, if the majority is 1 and there was no parity mismatch, push `shreg`. If the majority is 0, pulse `frame_err`, discard the byte, and go to WAIT_IDLE. A parity mismatch with a good stop pulses `parity_err`, discards the byte, and goes to IDLE. A good frame goes to IDLE immediately after commit (mid-stop), allowing back-to-back frames.
  - WAIT_IDLE: stay until `rx_s`=1, then go to IDLE. This keeps a break condition from producing garbage frames.
- FIFO:
  - Push when full and no pop in the same cycle: the byte is dropped, `overrun` pulses, and the contents are unchanged.
  - Pop occurs when `m_valid` && `m_ready`.
  - Simultaneous push and pop when full: both succeed, no overrun, and `fifo_count` is unchanged.
  - Simultaneous push and pop when empty: the push is stored, the pop is ignored (`m_valid` was 0), and `fifo_count` becomes 1.
- Reset (mid-frame included): state IDLE, FIFO empty, pointers 0, synchronizer = 1, divider and `os_cnt` = 0.
- Output values in reset: `m_valid`=0, `m_data`=0, `fifo_count`=0, `rx_busy`=0, all error pulses 0. A partially received frame is lost.

## Timing
- Start-detect latency: 3 cycles from the first `clk` edge that samples `rxd`=0 to state=START (2 synchronizer stages + edge register).
- Push occurs in the commit cycle of the stop bit. `m_valid` and `fifo_count` update on the next edge.
- With `DIV`=1 and 8N1, `m_valid` rises exactly 157 cycles after the first edge sampling `rxd`=0: 3 + 9·16 + 9 + 1. With `PARITY_EN`=1 it rises 16 cycles later. This latency is identical for every frame.
- Error pulses are asserted in the cycle after the commit edge and last exactly 1 cycle.
- `m_data` is the registered FIFO head. It is stable while `m_valid`=1 and `m_ready`=0, and the next entry appears on the edge after a pop.
- Tolerates ±4% baud mismatch with 16x oversampling.

## Test plan
- `DIV`=1, 8N1, send 0xA5 with `m_ready`=1 → `m_data`=0xA5, `m_valid` high for 1 cycle at +157 cycles, no error pulses.
- Send 0x00, 0xFF, 0x3C back-to-back (stop bit only 1 bit long) with `m_ready`=0 → `fifo_count`=3, then drain to receive 0x00, 0xFF, 0x3C in order.
- Hold `m_ready`=0 and send 5 bytes 0x01..0x05 with `FIFO_DEPTH`=4 → one `overrun` pulse at the fifth stop bit, FIFO holds 0x01..0x04. Repeat with `m_ready` pulsed in the fifth push cycle → no overrun, `fifo_count` stays 4.
- Send 0x55 with the stop bit forced to 0 followed by 40 cycles of low line → one `frame_err` pulse, nothing pushed, state WAIT_IDLE until `rxd`=1, then the next frame 0x12 is received correctly.
- Apply a 5-cycle low glitch on idle `rxd` → no push and no flags. Separately, `PARITY_EN`=1, `PARITY_ODD`=0, send 0x07 with parity 0 → `parity_err` pulse, nothing pushed.
- Assert `reset_n`=0 for 1 cycle during data bit 4 → all outputs 0 on the next cycle. The next full frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - 16x oversampled 8-bit UART receiver with majority voting and a receive FIFO
module uart_rx_sampler #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          rxd,
    output logic [7:0]                    m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          rx_busy,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);

    localparam int DIV_RAW = (CLK_FREQ_HZ + BAUD * 8) / (BAUD * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    logic          r_sync1;
    logic          r_rx_s;
    logic          r_rx_prev;
    logic          r_fall;
    logic [DW-1:0] r_div;
    logic [3:0]    r_os;
    logic          r_smp7;
    logic          r_smp8;
    state_t        r_state;
    logic [7:0]    r_shreg;
    logic [2:0]    r_bit_idx;
    logic          r_par_bad;
    logic          r_frame_err;
    logic          r_parity_err;
    logic          r_overrun;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_m_data;

    logic          w_tick;
    logic          w_commit;
    logic          w_bit_end;
    logic          w_maj;
    logic          w_par_exp;
    logic          w_push_req;
    logic          w_pop;
    logic          w_full;
    logic          w_push;
    logic          w_ovr;
    logic [AW-1:0] w_rd_next;
    logic [CW-1:0] w_count_after_pop;
    logic [7:0]    w_head_next;

    // Synchronizer plus a registered falling-edge flag; together they give the 3-cycle start latency.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1   <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
            r_fall    <= 1'b0;
        end else begin
            r_sync1   <= rxd;
            r_rx_s    <= r_sync1;
            r_rx_prev <= r_rx_s;
            r_fall    <= r_rx_prev & ~r_rx_s;
        end
    end

    assign w_tick     = (r_div == DW'(DIV - 1));
    assign w_commit   = w_tick && (r_os == 4'd9);
    assign w_bit_end  = w_tick && (r_os == 4'd15);
    assign w_maj      = (r_smp7 & r_smp8) | (r_smp7 & r_rx_s) | (r_smp8 & r_rx_s);
    assign w_par_exp  = (^r_shreg) ^ (PARITY_ODD != 0);
    assign w_push_req = (r_state == S_STOP) && w_commit && w_maj && !r_par_bad;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_div        <= '0;
            r_os         <= 4'd0;
            r_smp7       <= 1'b1;
            r_smp8       <= 1'b1;
            r_shreg      <= 8'h00;
            r_bit_idx    <= 3'd0;
            r_par_bad    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;

            if (w_tick) begin
                r_div <= '0;
                r_os  <= r_os + 4'd1;
            end else begin
                r_div <= r_div + DW'(1);
            end
            if (w_tick && r_os == 4'd7) r_smp7 <= r_rx_s;
            if (w_tick && r_os == 4'd8) r_smp8 <= r_rx_s;

            case (r_state)
                S_IDLE: begin
                    if (r_fall) begin
                        r_state <= S_START;
                        r_div   <= '0;
                        r_os    <= 4'd0;
                    end
                end
                S_START: begin
                    if (w_commit && w_maj) begin
                        r_state <= S_IDLE;
                    end else if (w_bit_end) begin
                        r_state   <= S_DATA;
                        r_bit_idx <= 3'd0;
                        r_par_bad <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (w_commit) r_shreg <= {w_maj, r_shreg[7:1]};
                    if (w_bit_end) begin
                        if (r_bit_idx == 3'd7) begin
                            r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_commit) r_par_bad <= (w_maj != w_par_exp);
                    if (w_bit_end) r_state <= S_STOP;
                end
                S_STOP: begin
                    // Leave mid-stop on a good frame so a following start bit is never missed.
                    if (w_commit) begin
                        if (!w_maj) begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_WAIT_IDLE;
                        end else begin
                            r_parity_err <= r_par_bad;
                            r_state      <= S_IDLE;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (r_rx_s) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_pop             = (r_count != '0) && m_ready;
    assign w_full            = (r_count == CW'(FIFO_DEPTH));
    assign w_push            = w_push_req && (!w_full || w_pop);
    assign w_ovr             = w_push_req && w_full && !w_pop;
    assign w_rd_next         = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
    assign w_count_after_pop = r_count - CW'(w_pop);

    // The head register takes the incoming byte only when every older entry is gone.
    always_comb begin
        w_head_next = 8'h00;
        if (w_count_after_pop != '0) begin
            w_head_next = r_mem[w_rd_next];
        end else if (w_push) begin
            w_head_next = r_shreg;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= r_shreg;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_m_data  <= 8'h00;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_ovr;
            r_m_data  <= w_head_next;
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            r_rd_ptr <= w_rd_next;
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign m_data     = r_m_data;
    assign m_valid    = (r_count != '0);
    assign fifo_count = r_count;
    assign rx_busy    = (r_state != S_IDLE) && (r_state != S_WAIT_IDLE);
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;

endmodule
